asic_iopoc_seq: RTL

- Power-on-control sequencer that generates the `poc` signal distributed around the IO ring, through the corner and pad cells.
- Holds all pads in their safe state until both supplies have been stable for a programmed settle time.
- Then releases `poc`, and only afterwards enables core-driven IO.
- Forces `poc` back on any supply loss. Sits in the always-on core domain, directly upstream of the IO ring `poc` feedthrough.

---
 rtl/asic_iopoc_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/asic_iopoc_seq.sv
// -----------------------------------------------------------------------------
// asic_iopoc_seq
//   Power-on-control sequencer for the IO ring. It keeps every pad in its safe
//   state (poc=1) until both supplies have been stable for SETTLE_CYCLES. It
//   then releases poc, and enables core-driven IO one cycle later. On any
//   supply loss it forces poc back on for at least HOLD_CYCLES.
//
// Ports
//   clk        in   sequencer clock
//   reset      in   asynchronous, active-high reset
//   en         in   sequencing enable (synchronous)
//   vddio_ok   in   IO supply power-good (asynchronous, synchronized here)
//   vdd_ok     in   core supply power-good (asynchronous, synchronized here)
//   fault_clr  in   clears the sticky fault flag (synchronous pulse)
//   poc        out  power-on-control to the IO ring, 1 = pads held safe
//   io_en      out  core IO drive/receive enable
//   state      out  current FSM state encoding
//   fault      out  sticky supply-loss flag
// -----------------------------------------------------------------------------
module asic_iopoc_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CW            = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       vddio_ok,
  input  logic       vdd_ok,
  input  logic       fault_clr,
  output logic       poc,
  output logic       io_en,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_QUIESCE = 3'd5,
    ST_FAULT   = 3'd6
  } state_e;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] vddio_sync_q, vddio_sync_d;
  logic [SYNC_STAGES-1:0] vdd_sync_q, vdd_sync_d;
  logic                   fault_q, fault_d;
  logic                   poc_q, poc_d;
  logic                   io_en_q, io_en_d;
  logic                   ok_s;
  logic                   fault_entry;

  // Power-good synchronizers: new sample enters at bit 0, oldest is the MSB.
  assign vddio_sync_d = {vddio_sync_q[SYNC_STAGES-2:0], vddio_ok};
  assign vdd_sync_d   = {vdd_sync_q[SYNC_STAGES-2:0], vdd_ok};
  assign ok_s         = vddio_sync_q[SYNC_STAGES-1] & vdd_sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = '0;  // counter rests at zero, so every SETTLE/FAULT entry starts clean
    unique case (state_q)
      ST_OFF:     if (en) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!en)       state_d = ST_OFF;
        else if (ok_s) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!en)                       state_d = ST_OFF;
        else if (!ok_s)                state_d = ST_WAIT;
        else if (cnt_q == SETTLE_LAST) state_d = ST_RELEASE;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      // Supply loss is checked before en in the released states.
      ST_RELEASE: begin
        if (!ok_s)    state_d = ST_FAULT;
        else if (!en) state_d = ST_QUIESCE;
        else          state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!ok_s)    state_d = ST_FAULT;
        else if (!en) state_d = ST_QUIESCE;
      end
      ST_QUIESCE: state_d = ok_s ? ST_OFF : ST_FAULT;
      // Supplies are ignored while holding; only the hold timer matters.
      ST_FAULT: begin
        if (cnt_q == HOLD_LAST) state_d = en ? ST_WAIT : ST_OFF;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      default:    state_d = ST_FAULT;  // encoding 7 is never legal
    endcase

    fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);
    // A new fault entry wins over a simultaneous clear.
    fault_d     = fault_entry | (fault_q & ~fault_clr);

    // Outputs are decoded from the next state so they flip with state_q.
    poc_d   = !(state_d inside {ST_RELEASE, ST_ACTIVE, ST_QUIESCE});
    io_en_d = (state_d == ST_ACTIVE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from values sampled at the same clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      vddio_sync_q <= '0;
      vdd_sync_q   <= '0;
      fault_q      <= 1'b0;
      poc_q        <= 1'b1;
      io_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vddio_sync_q <= vddio_sync_d;
      vdd_sync_q   <= vdd_sync_d;
      fault_q      <= fault_d;
      poc_q        <= poc_d;
      io_en_q      <= io_en_d;
    end
  end

  assign poc   = poc_q;
  assign io_en = io_en_q;
  assign state = state_q;
  assign fault = fault_q;

endmodule
